risc_ctrl_unit_p: RTL
=====================

Name: risc_ctrl_unit_p

Overview:
- Parametrised second-generation control FSM for the RISC-SPM datapath: register count, memory wait states, HALT opcode and illegal-opcode trapping.
- Decodes the instruction register and drives register/IR/PC/address-register load strobes, the two bus mux selects and the memory write strobe.
- Sits beside the processing unit and memory exactly as the first-generation controller does; datapath must supply NUM_REGS general registers.

Parameters:
- NUM_REGS, 4, number of general registers; power of 2, 2..16.
- RW, $clog2(NUM_REGS), derived: width of src/dst fields.
- IW, 4+2*RW, derived: instruction width; fields are opcode[IW-1:IW-4], src[2*RW-1:RW], dst[RW-1:0].
- S1W, $clog2(NUM_REGS+1), derived: Bus_1 select width; codes 0..NUM_REGS-1 = register, NUM_REGS = PC.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- instruction  in  IW  current IR contents.
- zflag  in  1  ALU zero flag register.
- mem_ready  in  1  memory completes the access this cycle.
- load_r  out  NUM_REGS  one-hot register load strobes.
- load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z, write  out  1 each  datapath strobes.
- sel_bus1  out  S1W  Bus_1 mux select.
- sel_bus2  out  2  Bus_2 select: 0 = ALU, 1 = Bus_1, 2 = memory.
- halted  out  1  FSM in HALT.
- err  out  1  sticky illegal-opcode flag.

Behaviour:
- Reset, asynchronous: state IDLE, err = 0. Outputs are combinational from state.
- All strobes and selects are 0 in every state that does not drive them. No x values.
- States: IDLE, FET1, FET2, DEC, EX1, RD1, RD2, WR1, WR2, BR1, BR2, HALT.
- IDLE -> FET1.
- FET1: sel_bus1 = PC, sel_bus2 = 1, load_add_r; -> FET2.
- FET2: sel_bus2 = 2. Wait while mem_ready = 0 with no strobes. On mem_ready: load_ir and inc_pc, -> DEC.
- DEC, by opcode:
  - NOP 0 -> FET1.
  - ADD 1, SUB 2, AND 3: sel_bus1 = src, sel_bus2 = 1, load_reg_y; -> EX1.
  - NOT 4: sel_bus1 = src, sel_bus2 = 0, load_reg_z, load_r[dst]; -> FET1.
  - RD 5, WR 6, BR 7: sel_bus1 = PC, sel_bus2 = 1, load_add_r; -> RD1, WR1 or BR1 respectively.
  - BRZ 8: if zflag, same strobes as BR, -> BR1; else -> FET1 with no strobes.
  - HALT 9 -> HALT.
  - Opcodes 10-15: set err, -> HALT.
- EX1: sel_bus1 = dst, sel_bus2 = 0, load_reg_z, load_r[dst]; -> FET1.
- RD1, WR1: sel_bus2 = 2. Wait for mem_ready; then load_add_r and inc_pc, -> RD2 or WR2.
- RD2: sel_bus2 = 2. Wait for mem_ready; then load_r[dst], -> FET1.
- WR2: sel_bus1 = src, write held high until mem_ready; -> FET1.
- BR1: sel_bus2 = 2. Wait for mem_ready; then load_add_r, -> BR2.
- BR2: sel_bus2 = 2. Wait for mem_ready; then load_pc, -> FET1.
- Each strobe pulses exactly one cycle per access regardless of wait length.
- HALT: halted = 1, no strobes; left only by reset. err holds until reset.
- mem_ready is ignored in non-memory states.
- Reset mid-instruction aborts without a completing strobe.
- Unused upper S1W codes are never driven.

Optional Feature:
- Macro CTRL_SINGLE_STEP_EN adds input step (1 bit).
- With the macro, FET1 advances, asserting its strobes, only in a cycle where step = 1; otherwise FET1 holds with all strobes 0.
- Without the macro, the port is absent and FET1 always advances.

Decomposition:
- Package risc_ctrl_pkg: opcode localparams (OP_NOP .. OP_HALT), state enum/localparams, BUS2_ALU/BUS2_BUS1/BUS2_MEM constants.
- Sub-module risc_reg_onehot (binary dst + enable -> NUM_REGS one-hot load vector), reused by NOT, EX1 and RD2.

Test Plan:
- NUM_REGS = 4, mem_ready = 1, instr 0x16 (ADD src1 dst2): DEC gives sel_bus1 = 1, sel_bus2 = 1, load_reg_y; EX1 gives load_r = 4'b0100, sel_bus1 = 2, load_reg_z; back in FET1 2 cycles after DEC.
- FET2 with mem_ready low 3 cycles: load_ir/inc_pc low throughout, single pulse on cycle 4, DEC on cycle 5.
- BRZ 0x80: zflag = 0 -> FET1, no load_add_r. zflag = 1 -> BR1, BR2, load_pc pulses once.
- WR 0x6C (src 3), mem_ready low 2 cycles in WR2: write high 3 cycles, sel_bus1 = 3.
- Instr 0xF0: next cycle err = 1, halted = 1, no strobes for 20 cycles; rst low clears both, FSM restarts at IDLE. Asserting rst during RD2 wait: load_r never pulses.
- NUM_REGS = 8, IW = 10, instr 10'b0100_101_011 (NOT src5 dst3): sel_bus1 = 5, load_r = 8'b0000_1000. With CTRL_SINGLE_STEP_EN, step held low: FSM stays in FET1, load_add_r = 0.

Source files
------------

// File: rtl/risc_ctrl_pkg.sv
// Shared opcodes, FSM states and Bus_2 select codes for the RISC-SPM controller.
package risc_ctrl_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_RD   = 4'd5;
    localparam logic [3:0] OP_WR   = 4'd6;
    localparam logic [3:0] OP_BR   = 4'd7;
    localparam logic [3:0] OP_BRZ  = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd9;

    localparam logic [1:0] BUS2_ALU  = 2'd0;
    localparam logic [1:0] BUS2_BUS1 = 2'd1;
    localparam logic [1:0] BUS2_MEM  = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_FET1, S_FET2, S_DEC, S_EX1,
        S_RD1, S_RD2, S_WR1, S_WR2, S_BR1, S_BR2, S_HALT
    } state_t;

endpackage

// File: rtl/risc_reg_onehot.sv
// Binary register index plus enable to a one-hot register load vector.
module risc_reg_onehot #(
    parameter int NUM_REGS = 4,
    localparam int RW = $clog2(NUM_REGS)
) (
    input  logic [RW-1:0]       idx,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
            assign onehot[gi] = en && (idx == RW'(gi));
        end
    endgenerate

endmodule

// File: rtl/risc_ctrl_unit_p.sv
// Parametrised RISC-SPM control FSM with memory wait states, HALT and illegal-opcode trap.
// Optional macro CTRL_SINGLE_STEP_EN adds a 'step' input gating progress out of FET1.
module risc_ctrl_unit_p
    import risc_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 4,
    localparam int RW  = $clog2(NUM_REGS),
    localparam int IW  = 4 + 2*RW,
    localparam int S1W = $clog2(NUM_REGS+1)
) (
    input  logic                clk,
    input  logic                rst,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic                step,
`endif
    input  logic [IW-1:0]       instruction,
    input  logic                zflag,
    input  logic                mem_ready,
    output logic [NUM_REGS-1:0] load_r,
    output logic                load_pc,
    output logic                inc_pc,
    output logic                load_ir,
    output logic                load_add_r,
    output logic                load_reg_y,
    output logic                load_reg_z,
    output logic                write,
    output logic [S1W-1:0]      sel_bus1,
    output logic [1:0]          sel_bus2,
    output logic                halted,
    output logic                err
);

    localparam logic [S1W-1:0] SEL_PC = S1W'(NUM_REGS);

    state_t state_reg, state_next;
    logic   err_reg, err_next;
    logic   ld_en;
    logic   step_ok;

    logic [3:0]     opcode;
    logic [RW-1:0]  src, dst;
    logic [S1W-1:0] src_sel, dst_sel;

    assign opcode  = instruction[IW-1:IW-4];
    assign src     = instruction[2*RW-1:RW];
    assign dst     = instruction[RW-1:0];
    assign src_sel = {{(S1W-RW){1'b0}}, src};
    assign dst_sel = {{(S1W-RW){1'b0}}, dst};
    assign err     = err_reg;

`ifdef CTRL_SINGLE_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;
        end
    end

    // Strobes depend on state and, in wait states, on mem_ready so each fires once per access.
    always_comb begin
        state_next = state_reg;
        err_next   = err_reg;
        ld_en      = 1'b0;
        load_pc    = 1'b0;
        inc_pc     = 1'b0;
        load_ir    = 1'b0;
        load_add_r = 1'b0;
        load_reg_y = 1'b0;
        load_reg_z = 1'b0;
        write      = 1'b0;
        sel_bus1   = '0;
        sel_bus2   = BUS2_ALU;
        halted     = 1'b0;
        case (state_reg)
            S_IDLE: state_next = S_FET1;
            S_FET1: if (step_ok) begin
                sel_bus1   = SEL_PC;
                sel_bus2   = BUS2_BUS1;
                load_add_r = 1'b1;
                state_next = S_FET2;
            end
            S_FET2: begin
                sel_bus2 = BUS2_MEM;
                if (mem_ready) begin
                    load_ir    = 1'b1;
                    inc_pc     = 1'b1;
                    state_next = S_DEC;
                end
            end
            S_DEC: case (opcode)
                OP_NOP: state_next = S_FET1;
                OP_ADD, OP_SUB, OP_AND: begin
                    sel_bus1   = src_sel;
                    sel_bus2   = BUS2_BUS1;
                    load_reg_y = 1'b1;
                    state_next = S_EX1;
                end
                OP_NOT: begin
                    sel_bus1   = src_sel;
                    sel_bus2   = BUS2_ALU;
                    load_reg_z = 1'b1;
                    ld_en      = 1'b1;
                    state_next = S_FET1;
                end
                OP_RD, OP_WR, OP_BR: begin
                    sel_bus1   = SEL_PC;
                    sel_bus2   = BUS2_BUS1;
                    load_add_r = 1'b1;
                    state_next = (opcode == OP_RD) ? S_RD1 :
                                 (opcode == OP_WR) ? S_WR1 : S_BR1;
                end
                OP_BRZ: begin
                    if (zflag) begin
                        sel_bus1   = SEL_PC;
                        sel_bus2   = BUS2_BUS1;
                        load_add_r = 1'b1;
                        state_next = S_BR1;
                    end else begin
                        state_next = S_FET1;
                    end
                end
                OP_HALT: state_next = S_HALT;
                default: begin
                    err_next   = 1'b1;
                    state_next = S_HALT;
                end
            endcase
            S_EX1: begin
                sel_bus1   = dst_sel;
                sel_bus2   = BUS2_ALU;
                load_reg_z = 1'b1;
                ld_en      = 1'b1;
                state_next = S_FET1;
            end
            S_RD1, S_WR1: begin
                sel_bus2 = BUS2_MEM;
                if (mem_ready) begin
                    load_add_r = 1'b1;
                    inc_pc     = 1'b1;
                    state_next = (state_reg == S_RD1) ? S_RD2 : S_WR2;
                end
            end
            S_RD2: begin
                sel_bus2 = BUS2_MEM;
                if (mem_ready) begin
                    ld_en      = 1'b1;
                    state_next = S_FET1;
                end
            end
            S_WR2: begin
                sel_bus1 = src_sel;
                write    = 1'b1;
                if (mem_ready) state_next = S_FET1;
            end
            S_BR1: begin
                sel_bus2 = BUS2_MEM;
                if (mem_ready) begin
                    load_add_r = 1'b1;
                    state_next = S_BR2;
                end
            end
            S_BR2: begin
                sel_bus2 = BUS2_MEM;
                if (mem_ready) begin
                    load_pc    = 1'b1;
                    state_next = S_FET1;
                end
            end
            S_HALT:  halted = 1'b1;
            default: state_next = S_IDLE;
        endcase
    end

    risc_reg_onehot #(.NUM_REGS(NUM_REGS)) u_onehot (
        .idx    (dst),
        .en     (ld_en),
        .onehot (load_r)
    );

endmodule
